// File: rtl/mc1.sv
// Machine-Check-1: 4-input Boolean function with a registered, valid-qualified
// copy of the result and a saturating count of captured ones.
module mc1 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             in_valid,
  output logic             f,
  output logic             f_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] ones_cnt
);

  wire a_n, b_n, c_n, d_n;
  wire t_ac, t_bd, t_abd, t_abc;

  // F = A'C' + BD + A'B'D' + AB'C
  not g_na (a_n, a);
  not g_nb (b_n, b);
  not g_nc (c_n, c);
  not g_nd (d_n, d);
  and g_t0 (t_ac,  a_n, c_n);
  and g_t1 (t_bd,  b,   d);
  and g_t2 (t_abd, a_n, b_n, d_n);
  and g_t3 (t_abc, a,   b_n, c);
  or  g_f  (f, t_ac, t_bd, t_abd, t_abc);

  logic             res_q, res_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    res_d = res_q;
    vld_d = in_valid;
    cnt_d = cnt_q;
    if (in_valid) begin
      res_d = f;
      if (f && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= 1'b0;
      vld_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      res_q <= res_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  assign f_q       = res_q;
  assign out_valid = vld_q;
  assign ones_cnt  = cnt_q;

endmodule

// File: tb/tb_mc1.sv
// Self-checking bench for mc1: directed test-plan steps plus random traffic,
// checked against a minterm-list reference model; a CNT_W=3 copy checks saturation.
module tb_mc1;

  logic       clk = 1'b0;
  logic       rst, a, b, c, d, in_valid;
  logic       f, f_q, out_valid;
  logic [7:0] ones_cnt;
  logic       f3, f_q3, out_valid3;
  logic [2:0] ones_cnt3;

  int total = 0;
  int bad   = 0;

  int exp_fq, exp_ov, exp_cnt, exp_cnt3;

  always #5 clk = ~clk;

  mc1 #(.CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
    .f(f), .f_q(f_q), .out_valid(out_valid), .ones_cnt(ones_cnt)
  );

  mc1 #(.CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d), .in_valid(in_valid),
    .f(f3), .f_q(f_q3), .out_valid(out_valid3), .ones_cnt(ones_cnt3)
  );

  function automatic int ref_f(input logic [3:0] idx);
    int ms[10] = '{0, 1, 2, 4, 5, 7, 10, 11, 13, 15};
    foreach (ms[i]) if (int'(idx) == ms[i]) return 1;
    return 0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [3:0] x);
    int fx;
    @(negedge clk);
    rst = r; in_valid = v; {a, b, c, d} = x;
    fx = ref_f(x);
    #1;
    check("f", int'(f), fx);
    @(posedge clk);
    if (r) begin
      exp_fq = 0; exp_ov = 0; exp_cnt = 0; exp_cnt3 = 0;
    end else if (v) begin
      exp_fq = fx;
      exp_ov = 1;
      if (fx == 1 && exp_cnt  < 255) exp_cnt++;
      if (fx == 1 && exp_cnt3 < 7)   exp_cnt3++;
    end else begin
      exp_ov = 0;
    end
    #1;
    check("f_q",        int'(f_q),        exp_fq);
    check("out_valid",  int'(out_valid),  exp_ov);
    check("ones_cnt",   int'(ones_cnt),   exp_cnt);
    check("ones_cnt3",  int'(ones_cnt3),  exp_cnt3);
    check("f_q3",       int'(f_q3),       exp_fq);
  endtask

  initial begin
    logic [3:0] x;
    rst = 1'b1; in_valid = 1'b0; {a, b, c, d} = 4'b0;
    exp_fq = 0; exp_ov = 0; exp_cnt = 0; exp_cnt3 = 0;

    // reset state
    step(1, 0, 4'b0000);
    step(1, 0, 4'b0000);
    check("reset_cnt", int'(ones_cnt), 0);

    // exhaustive combinational sweep
    for (int i = 0; i < 16; i++) step(0, 0, 4'(i));

    // registered capture back-to-back
    step(0, 1, 4'b0111);
    check("cap0_fq", int'(f_q), 1);
    step(0, 1, 4'b0011);
    check("cap1_fq", int'(f_q), 0);
    check("cap1_ov", int'(out_valid), 1);

    // hold
    step(0, 1, 4'b1010);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 4'b1000);
      check("hold_fq", int'(f_q), 1);
      check("hold_f",  int'(f), 0);
    end

    // counter sweep after reset
    step(1, 0, 4'b0000);
    for (int i = 0; i < 16; i++) step(0, 1, 4'(i));
    check("sweep_cnt",  int'(ones_cnt), 10);
    check("sweep_cnt3", int'(ones_cnt3), 7);

    // narrow counter saturation
    step(1, 0, 4'b0000);
    for (int i = 0; i < 16; i++) step(0, 1, 4'b1111);
    check("sat3", int'(ones_cnt3), 7);

    // reset priority over in_valid
    step(1, 1, 4'b0000);
    check("rstpri_fq",  int'(f_q), 0);
    check("rstpri_ov",  int'(out_valid), 0);
    check("rstpri_cnt", int'(ones_cnt), 0);
    check("rstpri_f",   int'(f), 1);

    // mid-operation reset
    for (int i = 0; i < 5; i++) step(0, 1, 4'b1111);
    check("mid_cnt5", int'(ones_cnt), 5);
    step(1, 0, 4'b1111);
    step(0, 1, 4'b1101);
    check("mid_cnt1", int'(ones_cnt), 1);
    check("mid_fq",   int'(f_q), 1);

    // full-width saturation
    for (int i = 0; i < 300; i++) step(0, 1, 4'b0101);
    check("sat8", int'(ones_cnt), 255);

    // random traffic
    step(1, 0, 4'b0000);
    for (int i = 0; i < 500; i++) begin
      x = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc1.md
Name: mc1

Overview:
- `mc1` is a 4-input single-output Boolean function unit with gate-level combinational logic.
- It has a registered, valid-qualified output stage and a saturating count of asserted results.
- It is the Machine-Check-1 logic block in the datapath. Its inputs are four independent control bits A, B, C, D, with A the MSB of the minterm index.
- Downstream logic consumes either the immediate combinational result or the one-cycle registered copy.

Parameters:
- CNT_W, 8, width of the saturating count of valid cycles where F=1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  1  operand bit A, minterm index bit 3 (MSB).
- b  input  1  operand bit B, minterm index bit 2.
- c  input  1  operand bit C, minterm index bit 1.
- d  input  1  operand bit D, minterm index bit 0 (LSB).
- in_valid  input  1  qualifies a/b/c/d for the registered path and the counter.
- f  output  1  combinational function result, no clock dependency.
- f_q  output  1  registered result, valid one cycle after capture.
- out_valid  output  1  high when f_q holds a captured result.
- ones_cnt  output  CNT_W  saturating count of captured results equal to 1.

Behaviour:
- Function: F(A,B,C,D) = Σm(0,1,2,4,5,7,10,11,13,15), with index = {A,B,C,D}.
  - F=1 for 0000, 0001, 0010, 0100, 0101, 0111, 1010, 1011, 1101, 1111.
  - F=0 for 0011, 0110, 1000, 1001, 1100, 1110.
- f is built from primitive gates (and/or/not) only, from the minimal SOP: F = A'C' + BD + A'B'D' + AB'C.
  - f responds to input changes combinationally in the same cycle.
  - f is independent of clk, rst and in_valid.
- Registered path, on each rising clk:
  - rst=1: f_q<=0, out_valid<=0, ones_cnt<=0. Reset has priority over in_valid.
  - rst=0, in_valid=1: f_q<=F(a,b,c,d), out_valid<=1.
  - rst=0, in_valid=0: f_q holds its value, out_valid<=0.
- Latency: exactly 1 cycle from in_valid sample to out_valid/f_q.
  - Back-to-back valid inputs produce back-to-back outputs with no bubbles.
- Counter:
  - When rst=0, in_valid=1 and F=1, ones_cnt increments by 1.
  - It saturates at 2^CNT_W-1 with no wrap.
  - Otherwise it holds.
  - It updates in the same edge as f_q, so it reflects the count including the current f_q.
- Reset asserted mid-stream:
  - The next edge clears all state.
  - A simultaneous in_valid on that edge is discarded and not counted.
- X/undefined inputs are not supported. Inputs are fully driven when in_valid=1.

Test Plan:
- Exhaustive sweep: rst=0, step {a,b,c,d} 0000→1111 every 10 time units → f = 1,1,1,0,1,1,0,1,0,0,1,1,0,1,0,1.
- Registered capture: in_valid=1 with 0111 at edge N, then 0011 at edge N+1 → after N: f_q=1, out_valid=1; after N+1: f_q=0, out_valid=1.
- Hold: after capturing 1010 (f_q=1), drop in_valid for 3 cycles with inputs 1000 → f_q stays 1, out_valid=0, ones_cnt unchanged, while f=0 combinationally.
- Counter: reset, then 16 valid cycles sweeping 0000..1111 → ones_cnt=10. With CNT_W=3, 16 valid cycles of 1111 → ones_cnt saturates at 7.
- Reset priority: rst=1 and in_valid=1 with 0000 on the same edge → f_q=0, out_valid=0, ones_cnt=0; f still reads 1.
- Mid-operation reset: ones_cnt=5, assert rst one cycle → ones_cnt=0. The next valid 1101 gives ones_cnt=1, f_q=1.
